victim_cache_ctrl: RTL and testbench

Parametrised fully-associative victim buffer for the data cache. Holds lines evicted from the D-cache with per-entry valid and dirty bits, and serves combinational tag lookups with optional take-on-hit (swap back into the cache). Uses round-robin replacement and forwards displaced dirty lines through a one-entry writeback register with a valid/ready handshake. Supports a flush sequence that drains all dirty entries.

---
 rtl/victim_cache_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_victim_cache_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/victim_cache_ctrl.sv
// ============================================================================
// victim_cache_ctrl : fully-associative D-cache victim buffer with round-robin
//                     replacement, writeback register and flush sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module victim_cache_ctrl #(
  parameter int NUM_ENTRIES = 4,
  parameter int LINE_WIDTH  = 128,
  parameter int TAG_WIDTH   = 23
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ins_valid_i,
  output logic                               ins_ready_o,
  input  logic [TAG_WIDTH-1:0]               ins_tag_i,
  input  logic [LINE_WIDTH-1:0]              ins_data_i,
  input  logic                               ins_dirty_i,
  input  logic [TAG_WIDTH-1:0]               lkp_tag_i,
  input  logic                               lkp_take_i,
  output logic                               hit_o,
  output logic [LINE_WIDTH-1:0]              hit_data_o,
  output logic                               hit_dirty_o,
  output logic                               wb_valid_o,
  input  logic                               wb_ready_i,
  output logic [TAG_WIDTH-1:0]               wb_tag_o,
  output logic [LINE_WIDTH-1:0]              wb_data_o,
  input  logic                               flush_i,
  output logic                               flush_busy_o,
  output logic                               flush_done_o,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   count_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_ENTRIES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0]    tag_q  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]    tag_d  [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0]   data_q [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0]   data_d [NUM_ENTRIES];
  logic [IDX_W-1:0]        rr_q, rr_d, fidx_q, fidx_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [TAG_WIDTH-1:0]    wb_tag_q, wb_tag_d;
  logic [LINE_WIDTH-1:0]   wb_data_q, wb_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_ENTRIES-1:0]  lkp_match, ins_match;
  logic                    hit_any, hit_dirty;
  logic [IDX_W-1:0]        hit_idx, ovr_idx, free_idx, tgt_idx;
  logic [LINE_WIDTH-1:0]   hit_data;
  logic                    ovr, free_any, replace, victim_dirty;
  logic                    ins_fire, take_fire;
  logic                    f_dirty, f_step, f_move;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_match
    assign lkp_match[g] = valid_q[g] && (tag_q[g] == lkp_tag_i);
    assign ins_match[g] = valid_q[g] && (tag_q[g] == ins_tag_i);
  end

  // Tags are unique among valid entries, so OR-combining the matches is a mux.
  always_comb begin
    hit_idx   = '0;
    hit_data  = '0;
    hit_dirty = 1'b0;
    ovr_idx   = '0;
    free_idx  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (lkp_match[i]) begin
        hit_idx   = IDX_W'(i);
        hit_data  = hit_data | data_q[i];
        hit_dirty = hit_dirty | dirty_q[i];
      end
      if (ins_match[i]) ovr_idx = IDX_W'(i);
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign hit_any      = |lkp_match;
  assign hit_o        = hit_any && (state_q != FLUSH);
  assign hit_data_o   = hit_o ? hit_data : '0;
  assign hit_dirty_o  = hit_o && hit_dirty;

  assign ovr          = |ins_match;
  assign free_any     = ~&valid_q;
  assign replace      = !ovr && !free_any;
  assign tgt_idx      = ovr ? ovr_idx : (free_any ? free_idx : rr_q);
  assign victim_dirty = replace && dirty_q[rr_q];

  assign ins_ready_o  = (state_q == IDLE) && !(victim_dirty && wb_valid_q && !wb_ready_i);
  assign ins_fire     = ins_valid_i && ins_ready_o;
  assign take_fire    = hit_o && lkp_take_i;

  // A dirty flush entry may only leave when the writeback slot is free or draining.
  assign f_dirty      = valid_q[fidx_q] && dirty_q[fidx_q];
  assign f_step       = (state_q == FLUSH) && (!f_dirty || !wb_valid_q || wb_ready_i);
  assign f_move       = f_step && f_dirty;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    rr_d       = rr_q;
    fidx_d     = fidx_q;
    wb_valid_d = wb_valid_q && !wb_ready_i;
    wb_tag_d   = wb_tag_q;
    wb_data_d  = wb_data_q;

    if (take_fire) begin
      valid_d[hit_idx] = 1'b0;
      dirty_d[hit_idx] = 1'b0;
    end

    if (ins_fire) begin
      valid_d[tgt_idx] = 1'b1;
      dirty_d[tgt_idx] = ovr ? (dirty_q[tgt_idx] | ins_dirty_i) : ins_dirty_i;
      tag_d[tgt_idx]   = ins_tag_i;
      data_d[tgt_idx]  = ins_data_i;
      if (replace) rr_d = rr_q + 1'b1;
      if (victim_dirty) begin
        wb_valid_d = 1'b1;
        wb_tag_d   = tag_q[rr_q];
        wb_data_d  = data_q[rr_q];
      end
    end

    if (f_move) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = tag_q[fidx_q];
      wb_data_d  = data_q[fidx_q];
    end

    case (state_q)
      IDLE: begin
        fidx_d = '0;
        if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (f_step) begin
          valid_d[fidx_q] = 1'b0;
          dirty_d[fidx_q] = 1'b0;
          fidx_d          = fidx_q + 1'b1;
          if (fidx_q == LAST_IDX) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      rr_q       <= '0;
      fidx_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      rr_q       <= rr_d;
      fidx_q     <= fidx_d;
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // Line storage is qualified by the valid bits and needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign wb_valid_o   = wb_valid_q;
  assign wb_tag_o     = wb_tag_q;
  assign wb_data_o    = wb_data_q;
  assign flush_busy_o = (state_q != IDLE);
  assign flush_done_o = (state_q == DONE);
  assign count_o      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_victim_cache_ctrl.sv
// ============================================================================
// tb_victim_cache_ctrl : directed self-checking bench for victim_cache_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_victim_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ins_valid_i = 1'b0;
  logic         ins_ready_o;
  logic [22:0]  ins_tag_i = '0;
  logic [127:0] ins_data_i = '0;
  logic         ins_dirty_i = 1'b0;
  logic [22:0]  lkp_tag_i = '0;
  logic         lkp_take_i = 1'b0;
  logic         hit_o;
  logic [127:0] hit_data_o;
  logic         hit_dirty_o;
  logic         wb_valid_o;
  logic         wb_ready_i = 1'b0;
  logic [22:0]  wb_tag_o;
  logic [127:0] wb_data_o;
  logic         flush_i = 1'b0;
  logic         flush_busy_o;
  logic         flush_done_o;
  logic [2:0]   count_o;

  int checks = 0;
  int errors = 0;
  int nwb    = 0;
  int ndone  = 0;
  logic [22:0] wbt [4];

  victim_cache_ctrl #(.NUM_ENTRIES(4), .LINE_WIDTH(128), .TAG_WIDTH(23)) dut (
    .clk(clk), .rst(rst),
    .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o), .ins_tag_i(ins_tag_i),
    .ins_data_i(ins_data_i), .ins_dirty_i(ins_dirty_i),
    .lkp_tag_i(lkp_tag_i), .lkp_take_i(lkp_take_i),
    .hit_o(hit_o), .hit_data_o(hit_data_o), .hit_dirty_o(hit_dirty_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] dat(input logic [22:0] t, input logic [7:0] v);
    return {4{t[7:0], v, 16'hC0DE}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the insert edge.
  task automatic ins(input logic [22:0] t, input logic d, input logic [7:0] v);
    ins_valid_i = 1'b1;
    ins_tag_i   = t;
    ins_data_i  = dat(t, v);
    ins_dirty_i = d;
    @(negedge clk);
    ins_valid_i = 1'b0;
  endtask

  task automatic look(input string tag, input logic [22:0] t, input logic exp_hit);
    lkp_tag_i = t;
    #1;
    chk(tag, 128'(hit_o), 128'(exp_hit));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    look("rst_hit0", 23'h0, 1'b0);
    chk("rst_count", 128'(count_o), 128'd0);
    chk("rst_ready", 128'(ins_ready_o), 128'd1);
    chk("rst_wbv", 128'(wb_valid_o), 128'd0);
    chk("rst_busy", 128'(flush_busy_o), 128'd0);
    chk("rst_hdata", hit_data_o, 128'd0);

    // Clean fill, then round-robin replacement of entry 0
    for (int i = 0; i < 4; i++) ins(23'h10 + 23'(i), 1'b0, 8'h00);
    chk("fill_count", 128'(count_o), 128'd4);
    ins(23'h14, 1'b0, 8'h00);
    chk("rr_count", 128'(count_o), 128'd4);
    chk("rr_wbv", 128'(wb_valid_o), 128'd0);
    look("rr_miss10", 23'h10, 1'b0);
    look("rr_hit14", 23'h14, 1'b1);
    chk("rr_data14", hit_data_o, dat(23'h14, 8'h00));

    // Dirty fill over clean victims (RR now 1): clean victims are dropped
    ins(23'h40, 1'b1, 8'h01);
    look("drop_miss11", 23'h11, 1'b0);
    chk("drop_wbv", 128'(wb_valid_o), 128'd0);
    ins(23'h41, 1'b1, 8'h01);
    ins(23'h42, 1'b1, 8'h01);
    ins(23'h43, 1'b1, 8'h01);
    ins(23'h44, 1'b1, 8'h01);
    chk("disp_wbv", 128'(wb_valid_o), 128'd1);
    chk("disp_tag", 128'(wb_tag_o), 128'h40);
    chk("disp_data", wb_data_o, dat(23'h40, 8'h01));
    ins_valid_i = 1'b1; ins_tag_i = 23'h45; ins_data_i = dat(23'h45, 8'h01); ins_dirty_i = 1'b1;
    #1;
    chk("bp_ready0", 128'(ins_ready_o), 128'd0);
    @(negedge clk);
    chk("bp_tag_stable", 128'(wb_tag_o), 128'h40);
    chk("bp_ready_hold", 128'(ins_ready_o), 128'd0);
    wb_ready_i = 1'b1;
    #1;
    chk("bp_ready1", 128'(ins_ready_o), 128'd1);
    @(negedge clk);
    ins_valid_i = 1'b0;
    chk("swap_wbv", 128'(wb_valid_o), 128'd1);
    chk("swap_tag", 128'(wb_tag_o), 128'h41);
    look("swap_hit45", 23'h45, 1'b1);
    @(negedge clk);
    wb_ready_i = 1'b0;
    chk("drain_wbv", 128'(wb_valid_o), 128'd0);

    // Take 0x43, then overwrite-in-place of 0x20
    lkp_tag_i = 23'h43; lkp_take_i = 1'b1;
    @(negedge clk);
    lkp_take_i = 1'b0;
    chk("take_count", 128'(count_o), 128'd3);
    look("take_miss43", 23'h43, 1'b0);
    ins(23'h20, 1'b0, 8'h02);
    chk("ovr_count_a", 128'(count_o), 128'd4);
    ins(23'h20, 1'b1, 8'h03);
    chk("ovr_count_b", 128'(count_o), 128'd4);
    look("ovr_hit20", 23'h20, 1'b1);
    chk("ovr_dirty", 128'(hit_dirty_o), 128'd1);
    chk("ovr_data", hit_data_o, dat(23'h20, 8'h03));
    chk("ovr_wbv", 128'(wb_valid_o), 128'd0);

    // Take 0x44 with insert 0x30 on a full buffer: RR victim is entry 3 (0x42, dirty)
    lkp_tag_i = 23'h44; lkp_take_i = 1'b1;
    ins(23'h30, 1'b0, 8'h04);
    lkp_take_i = 1'b0;
    chk("ti_count", 128'(count_o), 128'd3);
    look("ti_miss44", 23'h44, 1'b0);
    look("ti_hit30", 23'h30, 1'b1);
    look("ti_miss42", 23'h42, 1'b0);
    chk("ti_wbtag", 128'(wb_tag_o), 128'h42);
    wb_ready_i = 1'b1;
    @(negedge clk);
    wb_ready_i = 1'b0;
    // Take 0x45 with insert 0x31: goes to pre-edge free slot, net count unchanged
    lkp_tag_i = 23'h45; lkp_take_i = 1'b1;
    ins(23'h31, 1'b0, 8'h05);
    lkp_take_i = 1'b0;
    chk("ti2_count", 128'(count_o), 128'd3);
    look("ti2_hit31", 23'h31, 1'b1);
    look("ti2_miss45", 23'h45, 1'b0);
    chk("ti2_wbv", 128'(wb_valid_o), 128'd0);
    ins(23'h50, 1'b1, 8'h06);
    chk("pre_flush_count", 128'(count_o), 128'd4);

    // Flush: entries 0x20(d), 0x31, 0x50(d), 0x30
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("fl_busy", 128'(flush_busy_o), 128'd1);
    chk("fl_ready", 128'(ins_ready_o), 128'd0);
    lkp_tag_i = 23'h31;
    #1;
    chk("fl_nohit", 128'(hit_o), 128'd0);
    for (int c = 0; c < 30; c++) begin
      if (flush_done_o) ndone++;
      wb_ready_i = c[0];
      #1;
      if (wb_valid_o && wb_ready_i) begin
        if (nwb < 4) wbt[nwb] = wb_tag_o;
        nwb++;
      end
      @(negedge clk);
    end
    wb_ready_i = 1'b0;
    chk("fl_nwb", 128'(nwb), 128'd2);
    chk("fl_wb0", 128'(wbt[0]), 128'h20);
    chk("fl_wb1", 128'(wbt[1]), 128'h50);
    chk("fl_done", 128'(ndone), 128'd1);
    chk("fl_count", 128'(count_o), 128'd0);
    chk("fl_idle", 128'(flush_busy_o), 128'd0);
    chk("fl_wbv", 128'(wb_valid_o), 128'd0);

    // Reset asserted mid-flush with a pending writeback
    ins(23'h60, 1'b1, 8'h07);
    ins(23'h61, 1'b1, 8'h07);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    @(negedge clk);
    chk("mf_wbv", 128'(wb_valid_o), 128'd1);
    chk("mf_wbtag", 128'(wb_tag_o), 128'h60);
    rst = 1'b1;
    #1;
    chk("mf_rst_wbv", 128'(wb_valid_o), 128'd0);
    chk("mf_rst_busy", 128'(flush_busy_o), 128'd0);
    chk("mf_rst_count", 128'(count_o), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    look("mf_miss61", 23'h61, 1'b0);
    chk("mf_ready", 128'(ins_ready_o), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
